izh_calcium_sweep_ctrl: RTL and testbench

//  Sequences the calcium-leak update over every neuron on each time-reference event.

---
 rtl/izh_calcium_sweep_ctrl_pkg.sv | 25 ++
 rtl/izh_calcium_sweep_ctrl_addr_cnt.sv | 59 +++++
 rtl/izh_calcium_sweep_ctrl.sv | 168 ++++++++++++++++
 tb/tb_izh_calcium_sweep_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/izh_calcium_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// izh_calcium_sweep_ctrl_pkg
// Shared definitions for the calcium-leak sweep controller:
//   - sweep_state_e : FSM state encoding (IDLE=0, RD=1, WB=2, EVT=3)
//   - N_NEUR_DEF / ADDR_W_DEF : default neuron count and address width
//   - is_sram_state : true for states in which the sweep owns the SRAM port
// Optional feature macro used by the controller: CA_SWEEP_SKIP_EN.
// -----------------------------------------------------------------------------
package izh_calcium_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WB   = 2'd2,
        ST_EVT  = 2'd3
    } sweep_state_e;

    localparam int N_NEUR_DEF = 256;
    localparam int ADDR_W_DEF = 8;

    function automatic logic is_sram_state(input sweep_state_e st);
        return (st == ST_RD) || (st == ST_WB);
    endfunction

endpackage

// File: rtl/izh_calcium_sweep_ctrl_addr_cnt.sv
// -----------------------------------------------------------------------------
// izh_sweep_addr_cnt
// Neuron address counter for the calcium sweep. Advances by one on i_inc and
// returns to 0 only after N_NEUR-1 (never free-wraps at 2**ADDR_W).
// Ports:
//   i_clk, i_rstn  : clock, asynchronous active-low reset
//   i_inc          : advance the counter this cycle
//   o_cnt          : current neuron address
//   o_cnt_nxt      : address the counter will hold after this edge
//   o_tc           : terminal count, o_cnt == N_NEUR-1
// -----------------------------------------------------------------------------
module izh_sweep_addr_cnt
    import izh_calcium_sweep_ctrl_pkg::*;
#(
    parameter int N_NEUR = N_NEUR_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_cnt,
    output logic [ADDR_W-1:0] o_cnt_nxt,
    output logic              o_tc
);

    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_tc;

    assign w_tc = (r_cnt == ADDR_W'(N_NEUR - 1));

    // Next-count selection: hold, increment, or return to neuron 0 at terminal count.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_inc) begin
            if (w_tc) begin
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + ADDR_W'(1);
            end
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_cnt_nxt = w_cnt_nxt;
    assign o_tc      = w_tc;

endmodule

// File: rtl/izh_calcium_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// izh_calcium_sweep_ctrl
// On every time-reference strobe, walks all N_NEUR neurons with an atomic
// read / write-back pair on the neuron-state SRAM, asserting o_tref_en in the
// write-back cycle. The spike-event path may take the shared port, but only
// between neurons, never between a neuron's read and its write-back.
// Ports:
//   i_clk, i_rstn      : clock, asynchronous active-low reset
//   i_tref_pulse       : one-cycle time-reference strobe
//   i_evt_req          : event path port request (held until o_evt_gnt)
//   i_evt_done         : event path releases the port (one-cycle pulse)
//   i_skip_neur        : (CA_SWEEP_SKIP_EN only) suppress write-back of this neuron
//   o_evt_gnt          : event path owns the SRAM port
//   o_sweep_busy       : sweep in progress or pending
//   o_sram_cs/we/addr  : sweep-side SRAM controls
//   o_tref_en          : calcium datapath time-reference enable (write-back only)
//   o_tref_overrun     : sticky, strobe arrived while a sweep was pending
// Configuration macro: CA_SWEEP_SKIP_EN adds i_skip_neur, which is sampled in
// the write-back cycle and gates o_sram_we / o_tref_en without changing timing.
// -----------------------------------------------------------------------------
module izh_calcium_sweep_ctrl
    import izh_calcium_sweep_ctrl_pkg::*;
#(
    parameter int N_NEUR = N_NEUR_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_tref_pulse,
    input  logic              i_evt_req,
    input  logic              i_evt_done,
`ifdef CA_SWEEP_SKIP_EN
    input  logic              i_skip_neur,
`endif
    output logic              o_evt_gnt,
    output logic              o_sweep_busy,
    output logic              o_sram_cs,
    output logic              o_sram_we,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_tref_en,
    output logic              o_tref_overrun
);

    sweep_state_e      r_state;
    sweep_state_e      w_state_nxt;
    logic              r_pending;
    logic              w_pending_nxt;
    logic              r_overrun;
    logic              w_overrun_nxt;
    logic              w_inc;
    logic              w_last_wb;
    logic              w_tc;
    logic [ADDR_W-1:0] w_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_cs;
    logic              r_we;
    logic              r_tref_en;
    logic              r_gnt;
    logic [ADDR_W-1:0] r_addr;

    izh_sweep_addr_cnt #(
        .N_NEUR (N_NEUR),
        .ADDR_W (ADDR_W)
    ) u_addr_cnt (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_inc     (w_inc),
        .o_cnt     (w_cnt),
        .o_cnt_nxt (w_cnt_nxt),
        .o_tc      (w_tc)
    );

    assign w_last_wb = (r_state == ST_WB) && w_tc;

    // Next-state, pending/overrun and counter-advance decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_overrun_nxt = r_overrun;
        w_inc         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_evt_req) begin
                    w_state_nxt = ST_EVT;
                end else if (r_pending) begin
                    w_state_nxt = ST_RD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD: begin
                w_state_nxt = ST_WB;
            end
            ST_WB: begin
                w_inc = 1'b1;
                if (i_evt_req) begin
                    w_state_nxt = ST_EVT;
                end else if (w_tc) begin
                    // A strobe on the final write-back starts the next sweep at once.
                    w_state_nxt = i_tref_pulse ? ST_RD : ST_IDLE;
                end else begin
                    w_state_nxt = ST_RD;
                end
            end
            ST_EVT: begin
                if (i_evt_done) begin
                    w_state_nxt = r_pending ? ST_RD : ST_IDLE;
                end else begin
                    w_state_nxt = ST_EVT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_last_wb) begin
            w_pending_nxt = i_tref_pulse;
        end else if (i_tref_pulse) begin
            if (r_pending) begin
                w_overrun_nxt = 1'b1;
            end else begin
                w_pending_nxt = 1'b1;
            end
        end else begin
            w_pending_nxt = r_pending;
        end
    end

    // State, pending/overrun flags and output registers (outputs decoded from next state).
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_cs      <= 1'b0;
            r_we      <= 1'b0;
            r_tref_en <= 1'b0;
            r_gnt     <= 1'b0;
            r_addr    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_overrun <= w_overrun_nxt;
            r_cs      <= is_sram_state(w_state_nxt);
            r_we      <= (w_state_nxt == ST_WB);
            r_tref_en <= (w_state_nxt == ST_WB);
            r_gnt     <= (w_state_nxt == ST_EVT);
            r_addr    <= is_sram_state(w_state_nxt) ? w_cnt_nxt : '0;
        end
    end

`ifdef CA_SWEEP_SKIP_EN
    // Skip comes from this cycle's read data, so it can only gate the registered enables.
    assign o_sram_we = r_we & ~i_skip_neur;
    assign o_tref_en = r_tref_en & ~i_skip_neur;
`else
    assign o_sram_we = r_we;
    assign o_tref_en = r_tref_en;
`endif

    assign o_evt_gnt      = r_gnt;
    assign o_sweep_busy   = r_pending;
    assign o_sram_cs      = r_cs;
    assign o_sram_addr    = r_addr;
    assign o_tref_overrun = r_overrun;

endmodule

// File: tb/tb_izh_calcium_sweep_ctrl.sv
module tb_izh_calcium_sweep_ctrl;

    localparam int N      = 256;
    localparam int ADDR_W = 8;

    typedef enum int {ACT_NONE, ACT_READ, ACT_WRITE, ACT_EVENT} port_act_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic tref = 1'b0;
    logic evt_req = 1'b0;
    logic evt_done = 1'b0;
    logic skip_mode = 1'b0;
    logic o_evt_gnt, o_sweep_busy, o_sram_cs, o_sram_we, o_tref_en, o_tref_overrun;
    logic [ADDR_W-1:0] o_sram_addr;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: what the shared port is used for this cycle, plus sweep bookkeeping.
    port_act_t m_act;
    int        m_cur;
    logic      m_pend;
    logic      m_ovr;

    always #5 clk = ~clk;

`ifdef CA_SWEEP_SKIP_EN
    logic skip_neur;
    assign skip_neur = skip_mode & o_sram_addr[0];
`endif

    izh_calcium_sweep_ctrl #(.N_NEUR(N), .ADDR_W(ADDR_W)) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_tref_pulse   (tref),
        .i_evt_req      (evt_req),
        .i_evt_done     (evt_done),
`ifdef CA_SWEEP_SKIP_EN
        .i_skip_neur    (skip_neur),
`endif
        .o_evt_gnt      (o_evt_gnt),
        .o_sweep_busy   (o_sweep_busy),
        .o_sram_cs      (o_sram_cs),
        .o_sram_we      (o_sram_we),
        .o_sram_addr    (o_sram_addr),
        .o_tref_en      (o_tref_en),
        .o_tref_overrun (o_tref_overrun)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model update from the inputs the DUT samples on this edge.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_act  <= ACT_NONE;
            m_cur  <= 0;
            m_pend <= 1'b0;
            m_ovr  <= 1'b0;
        end else begin
            case (m_act)
                ACT_NONE:  m_act <= evt_req ? ACT_EVENT : (m_pend ? ACT_READ : ACT_NONE);
                ACT_READ:  m_act <= ACT_WRITE;
                ACT_WRITE: begin
                    if (m_cur == N - 1) begin
                        m_cur  <= 0;
                        m_pend <= tref;
                        m_act  <= evt_req ? ACT_EVENT : (tref ? ACT_READ : ACT_NONE);
                    end else begin
                        m_cur <= m_cur + 1;
                        m_act <= evt_req ? ACT_EVENT : ACT_READ;
                    end
                end
                ACT_EVENT: if (evt_done) m_act <= m_pend ? ACT_READ : ACT_NONE;
                default:   m_act <= ACT_NONE;
            endcase
            if (tref && !(m_act == ACT_WRITE && m_cur == N - 1)) begin
                if (m_pend) m_ovr <= 1'b1;
                else        m_pend <= 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison on the falling edge.
    always @(negedge clk) begin
        logic uses_port, skipped;
        uses_port = (m_act == ACT_READ) || (m_act == ACT_WRITE);
        skipped   = skip_mode && (m_cur % 2 == 1);
        chk("cs",      int'(o_sram_cs),      int'(uses_port));
        chk("we",      int'(o_sram_we),      int'(m_act == ACT_WRITE && !skipped));
        chk("tref_en", int'(o_tref_en),      int'(m_act == ACT_WRITE && !skipped));
        chk("addr",    int'(o_sram_addr),    uses_port ? m_cur : 0);
        chk("gnt",     int'(o_evt_gnt),      int'(m_act == ACT_EVENT));
        chk("busy",    int'(o_sweep_busy),   int'(m_pend));
        chk("overrun", int'(o_tref_overrun), int'(m_ovr));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_tref();
        tref = 1'b1;
        tick();
        tref = 1'b0;
    endtask

    task automatic wait_model(input port_act_t act, input int cur, input string name);
        int k;
        for (k = 0; k < 3000; k++) begin
            if (m_act == act && m_cur == cur) break;
            tick();
        end
        if (k == 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: timeout waiting for neuron %0d", name, cur);
        end
    endtask

    // Run until the sweep is over, counting port activity seen after each edge.
    task automatic run_to_idle(input string name, output int n_cs, output int n_te);
        int k;
        n_cs = 0;
        n_te = 0;
        for (k = 0; k < 3000; k++) begin
            if (!m_pend && m_act == ACT_NONE) break;
            tick();
            n_cs += int'(o_sram_cs);
            n_te += int'(o_tref_en);
        end
        if (k == 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: sweep did not end", name);
        end
    endtask

    initial begin
        int n_cs, n_te, ev, dur;

        // Reset state.
        repeat (3) tick();
        chk("rst_cs", int'(o_sram_cs), 0);
        chk("rst_busy", int'(o_sweep_busy), 0);
        chk("rst_gnt", int'(o_evt_gnt), 0);
        rstn = 1'b1;
        repeat (2) tick();

        // Full sweep with no events.
        pulse_tref();
        chk("t1_busy_rise", int'(o_sweep_busy), 1);
        run_to_idle("t1", n_cs, n_te);
        chk("t1_cs_cycles", n_cs, 512);
        chk("t1_tref_en_count", n_te, 256);
        chk("t1_busy_end", int'(o_sweep_busy), 0);

        // Event request raised during the read of neuron 10.
        pulse_tref();
        wait_model(ACT_READ, 10, "t2_wait");
        evt_req = 1'b1;
        tick();
        chk("t2_wb_we", int'(o_sram_we), 1);
        chk("t2_wb_addr", int'(o_sram_addr), 10);
        chk("t2_wb_nogrant", int'(o_evt_gnt), 0);
        tick();
        chk("t2_gnt", int'(o_evt_gnt), 1);
        evt_req = 1'b0;
        repeat (3) tick();
        evt_done = 1'b1;
        tick();
        evt_done = 1'b0;
        chk("t2_resume_cs", int'(o_sram_cs), 1);
        chk("t2_resume_addr", int'(o_sram_addr), 11);
        run_to_idle("t2", n_cs, n_te);

        // Strobe while a sweep is pending.
        pulse_tref();
        chk("t3_no_overrun", int'(o_tref_overrun), 0);
        wait_model(ACT_READ, 100, "t3_wait");
        pulse_tref();
        chk("t3_overrun", int'(o_tref_overrun), 1);
        run_to_idle("t3", n_cs, n_te);
        n_cs = 0;
        repeat (20) begin
            tick();
            n_cs += int'(o_sram_cs) + int'(o_sweep_busy);
        end
        chk("t3_no_second_sweep", n_cs, 0);

        // Strobe coincident with the final write-back.
        pulse_tref();
        wait_model(ACT_WRITE, 255, "t4_wait");
        pulse_tref();
        chk("t4_rd_cs", int'(o_sram_cs), 1);
        chk("t4_rd_we", int'(o_sram_we), 0);
        chk("t4_rd_addr", int'(o_sram_addr), 0);
        chk("t4_busy", int'(o_sweep_busy), 1);
        run_to_idle("t4", n_cs, n_te);
        chk("t4_tref_en_count", n_te, 256);

        // Reset during write-back of neuron 50.
        pulse_tref();
        wait_model(ACT_WRITE, 50, "t5_wait");
        rstn = 1'b0;
        #1;
        chk("t5_async_cs", int'(o_sram_cs), 0);
        chk("t5_async_we", int'(o_sram_we), 0);
        chk("t5_async_addr", int'(o_sram_addr), 0);
        chk("t5_async_busy", int'(o_sweep_busy), 0);
        chk("t5_async_overrun", int'(o_tref_overrun), 0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        pulse_tref();
        tick();
        chk("t5_restart_cs", int'(o_sram_cs), 1);
        chk("t5_restart_addr", int'(o_sram_addr), 0);
        run_to_idle("t5", n_cs, n_te);

`ifdef CA_SWEEP_SKIP_EN
        // Odd neurons skipped: half the write-backs, same timing.
        skip_mode = 1'b1;
        pulse_tref();
        run_to_idle("t6", n_cs, n_te);
        chk("t6_cs_cycles", n_cs, 512);
        chk("t6_tref_en_count", n_te, 128);
        skip_mode = 1'b0;
`endif

        // Random strobes and event traffic.
        ev = 0;
        dur = 0;
        repeat (5000) begin
            tref = ($urandom_range(0, 399) == 0);
            evt_done = 1'b0;
            case (ev)
                0: if ($urandom_range(0, 49) == 0) begin evt_req = 1'b1; ev = 1; end
                1: if (o_evt_gnt) begin evt_req = 1'b0; dur = int'($urandom_range(0, 3)); ev = 2; end
                default: begin
                    if (dur == 0) begin evt_done = 1'b1; ev = 0; end
                    else dur--;
                end
            endcase
            tick();
        end
        tref = 1'b0;
        evt_req = 1'b0;
        evt_done = 1'b0;
        if (ev == 2) begin
            evt_done = 1'b1;
            tick();
            evt_done = 1'b0;
        end
        run_to_idle("rand_drain", n_cs, n_te);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
